counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter N, default 4: width of the controlled up_down_counter.
REQ-002 Parameter PASS_W, default 4: width of the pass-count field.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-006 abort  input  1  terminate an active sequence without asserting done.
REQ-007 dir  input  1  count direction for the sequence: 1 = up, 0 = down.
REQ-008 preset  input  N  value loaded at the start of every pass.
REQ-009 passes  input  PASS_W  number of terminal-count events to run.
REQ-010 rco_b  input  1  counter ripple-carry, active low: terminal count for the current direction (all-ones up, zero down).
REQ-011 cnt_en_b  output  1  counter enable, active low.
REQ-012 cnt_load_b  output  1  counter synchronous load, active low.
REQ-013 cnt_up  output  1  counter direction.
REQ-014 cnt_load_in  output  N  counter load value.
REQ-015 busy  output  1  high in LOAD and RUN.
REQ-016 pass_done  output  1  one-cycle pulse per completed pass.
REQ-017 done  output  1  one-cycle pulse when a sequence completes normally.
REQ-018 pass_cnt  output  PASS_W  number of passes completed in the current or last sequence.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-020 cnt_en_b, cnt_load_b, busy and done SHALL be decoded only from the state register; they SHALL NOT have a combinational path from any input.
REQ-021 In IDLE and DONE: cnt_en_b=1 and cnt_load_b=1.
REQ-022 In LOAD: cnt_load_b=0 and cnt_en_b=1.
REQ-023 In RUN: cnt_en_b=0 and cnt_load_b=1.
REQ-024 On the edge that samples start=1 in IDLE, the block SHALL latch preset, dir and passes into internal registers and clear pass_cnt to 0.
REQ-025 cnt_load_in and cnt_up SHALL always drive the latched preset and dir; input changes during a sequence SHALL have no effect.
REQ-026 start=1 in IDLE with passes!=0 SHALL move the FSM to LOAD.
REQ-027 start=1 in IDLE with passes==0 SHALL move the FSM directly to DONE, with no load and no enable.
REQ-028 LOAD SHALL last exactly 1 cycle, then move to RUN.
REQ-029 In RUN, sampling rco_b=0 SHALL increment pass_cnt and pulse pass_done in the following cycle.
REQ-030 After that increment, if pass_cnt equals the latched passes the FSM SHALL go to DONE; otherwise it SHALL go to LOAD.
REQ-031 The counter advances on the edge where rco_b=0 is sampled. After DONE, the counter holds the wrapped value: 0 when counting up, all-ones when counting down.
REQ-032 A preset already at the terminal value SHALL produce a pass on the first RUN cycle (zero counts).
REQ-033 DONE SHALL last exactly 1 cycle with done=1, then move to IDLE.
REQ-034 start asserted in a state other than IDLE SHALL be ignored.
REQ-035 abort=1 in LOAD or RUN SHALL move the FSM to IDLE on the next edge, with done=0 and pass_cnt held.
REQ-036 abort SHALL take priority over rco_b when both are active in the same cycle.
REQ-037 abort in IDLE or DONE SHALL have no effect; DONE still completes.
REQ-038 pass_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-039 reset=1 SHALL force, on the next edge, state=IDLE and pass_cnt=0.
REQ-040 reset=1 SHALL clear the latched preset and dir to 0 and the latched passes to 0.
REQ-041 During and after reset the outputs SHALL be: cnt_en_b=1, cnt_load_b=1, cnt_up=0, cnt_load_in=0, busy=0, pass_done=0, done=0.
REQ-042 reset SHALL override start and abort.
REQ-043 reset in any state, including mid-RUN, SHALL abandon the sequence with no done pulse.

Verification (N=4 counter attached)
REQ-044 start, dir=1, preset=0, passes=1 -> LOAD 1 cycle, then RUN with q counting 0..15; rco_b low at q=15; done pulses once; pass_cnt=1; q=0 after done.
REQ-045 start, dir=0, preset=4'b1010, passes=3 -> three LOAD pulses and three pass_done pulses, each pass counting 10..0 (11 RUN cycles); done after the third; pass_cnt=3.
REQ-046 start with passes=0 -> done the next cycle; cnt_load_b and cnt_en_b never low; pass_cnt=0.
REQ-047 dir=1, preset=4'b1111, passes=2 -> each RUN lasts 1 cycle; pass_done twice; done; pass_cnt=2.
REQ-048 abort mid-RUN, and separately reset mid-RUN -> IDLE next cycle, cnt_en_b=1, no done. After reset pass_cnt=0; after abort pass_cnt is held.
REQ-049 start pulsed while busy, and preset/dir changed mid-sequence -> no restart; the counter is reloaded with the originally latched values.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - multi-pass sequencer driving an external up/down counter
module counter_seq_ctrl #(
    parameter int N      = 4,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              dir,
    input  logic [N-1:0]      preset,
    input  logic [PASS_W-1:0] passes,
    input  logic              rco_b,
    output logic              cnt_en_b,
    output logic              cnt_load_b,
    output logic              cnt_up,
    output logic [N-1:0]      cnt_load_in,
    output logic              busy,
    output logic              pass_done,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [N-1:0]      preset_q;
    logic              dir_q;
    logic [PASS_W-1:0] passes_q;
    logic [PASS_W-1:0] pass_next;

    assign pass_next = pass_cnt + {{(PASS_W-1){1'b0}}, 1'b1};

    // Sequencer state, latched sequence parameters and pass bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            preset_q  <= '0;
            dir_q     <= 1'b0;
            passes_q  <= '0;
            pass_cnt  <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        preset_q <= preset;
                        dir_q    <= dir;
                        passes_q <= passes;
                        pass_cnt <= '0;
                        // a zero-pass request completes without touching the counter
                        state    <= (passes == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    // abort wins over a coincident terminal count
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (!rco_b) begin
                        pass_cnt  <= pass_next;
                        pass_done <= 1'b1;
                        state     <= (pass_next == passes_q) ? S_DONE : S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Counter controls and status are pure state decodes, never input-dependent
    assign cnt_en_b    = (state != S_RUN);
    assign cnt_load_b  = (state != S_LOAD);
    assign busy        = (state == S_LOAD) || (state == S_RUN);
    assign done        = (state == S_DONE);
    assign cnt_up      = dir_q;
    assign cnt_load_in = preset_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - scoreboard bench for counter_seq_ctrl with a 4-bit counter model
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       dir;
    logic [3:0] preset;
    logic [3:0] passes;
    logic       rco_b;
    logic       cnt_en_b;
    logic       cnt_load_b;
    logic       cnt_up;
    logic [3:0] cnt_load_in;
    logic       busy;
    logic       pass_done;
    logic       done;
    logic [3:0] pass_cnt;
    logic [3:0] q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;   // 0 = pass_done, 1 = done
        int pc;
        int qv;
        int loads;
        int runs;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    counter_seq_ctrl #(.N(4), .PASS_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .dir         (dir),
        .preset      (preset),
        .passes      (passes),
        .rco_b       (rco_b),
        .cnt_en_b    (cnt_en_b),
        .cnt_load_b  (cnt_load_b),
        .cnt_up      (cnt_up),
        .cnt_load_in (cnt_load_in),
        .busy        (busy),
        .pass_done   (pass_done),
        .done        (done),
        .pass_cnt    (pass_cnt)
    );

    // external up/down counter with active-low load/enable and ripple carry
    always @(posedge clk) begin
        if (!cnt_load_b)
            q <= cnt_load_in;
        else if (!cnt_en_b)
            q <= cnt_up ? q + 4'd1 : q - 4'd1;
    end
    assign rco_b = ~((cnt_up && q == 4'hF) || (!cnt_up && q == 4'h0));

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic push_pass(input int pc, input int qv);
        exp_t e;
        e.kind = 0; e.pc = pc; e.qv = qv; e.loads = 0; e.runs = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int pc, input int qv, input int loads, input int runs);
        exp_t e;
        e.kind = 1; e.pc = pc; e.qv = qv; e.loads = loads; e.runs = runs;
        exp_q.push_back(e);
    endtask

    // monitor: counts LOAD/RUN cycles per sequence and checks every pass_done/done
    int n_loads = 0;
    int n_runs  = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset || (start && !busy && !done)) begin
                n_loads = 0;
                n_runs  = 0;
            end else begin
                if (!cnt_load_b) n_loads++;
                if (!cnt_en_b)   n_runs++;
            end
            if (pass_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pass_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pass_kind", 0, e.kind);
                    chk("pass_cnt_at_pass", int'(pass_cnt), e.pc);
                    chk("q_at_pass", int'(q), e.qv);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 1, e.kind);
                    chk("pass_cnt_at_done", int'(pass_cnt), e.pc);
                    chk("q_at_done", int'(q), e.qv);
                    chk("load_cycles", n_loads, e.loads);
                    chk("run_cycles", n_runs, e.runs);
                end
            end
        end
    end

    task automatic do_start(input bit d, input logic [3:0] p, input logic [3:0] n);
        @(posedge clk); #1;
        dir = d; preset = p; passes = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat = i;
                break;
            end
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_pass(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pass_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_pass_seen"}, int'(seen), 1);
    endtask

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        dir = 1'b1; preset = 4'h9; passes = 4'h5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt_en_b", int'(cnt_en_b), 1);
        chk("rst_cnt_load_b", int'(cnt_load_b), 1);
        chk("rst_cnt_up", int'(cnt_up), 0);
        chk("rst_cnt_load_in", int'(cnt_load_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pass_done", int'(pass_done), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass_cnt", int'(pass_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // up from 0, one pass: 16 RUN cycles, wraps to 0
        push_pass(1, 0);
        push_done(1, 0, 1, 16);
        do_start(1'b1, 4'h0, 4'd1);
        wait_done("up1", lat);

        // down from 10, three passes of 11 RUN cycles each
        push_pass(1, 15); push_pass(2, 15); push_pass(3, 15);
        push_done(3, 15, 3, 33);
        do_start(1'b0, 4'hA, 4'd3);
        wait_done("down3", lat);

        // zero passes: done straight away, counter untouched at 15
        push_done(0, 15, 0, 0);
        do_start(1'b1, 4'h3, 4'd0);
        wait_done("zero", lat);
        chk("zero_done_latency", lat, 0);

        // preset already terminal: one RUN cycle per pass
        push_pass(1, 0); push_pass(2, 0);
        push_done(2, 0, 2, 2);
        do_start(1'b1, 4'hF, 4'd2);
        wait_done("term", lat);

        // restart attempt and input changes mid-sequence are ignored
        push_pass(1, 0); push_pass(2, 0);
        push_done(2, 0, 2, 8);
        do_start(1'b1, 4'hC, 4'd2);
        preset = 4'h3; dir = 1'b0; passes = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("latched_load_in", int'(cnt_load_in), 12);
        chk("latched_up", int'(cnt_up), 1);
        wait_done("latch", lat);

        // abort held through IDLE and DONE of a zero-pass sequence has no effect
        push_done(0, 0, 0, 0);
        abort = 1'b1;
        do_start(1'b1, 4'h5, 4'd0);
        wait_done("abort_idle", lat);
        abort = 1'b0;

        // abort mid-RUN of the second pass: back to IDLE, pass_cnt held at 1
        push_pass(1, 0);
        do_start(1'b1, 4'hE, 4'd2);
        wait_pass("abort_run");
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cnt_en_b", int'(cnt_en_b), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_pass_cnt", int'(pass_cnt), 1);
        repeat (3) @(negedge clk);
        chk("idle_pass_cnt_hold", int'(pass_cnt), 1);

        // abort coincident with terminal count: abort wins, no pass recorded
        do_start(1'b1, 4'hF, 4'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("prio_busy", int'(busy), 0);
        chk("prio_pass_cnt", int'(pass_cnt), 0);

        // reset mid-RUN after one pass: sequence dropped, pass_cnt cleared
        push_pass(1, 0);
        do_start(1'b1, 4'hE, 4'd2);
        wait_pass("reset_run");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rrun_busy", int'(busy), 0);
        chk("rrun_cnt_en_b", int'(cnt_en_b), 1);
        chk("rrun_cnt_up", int'(cnt_up), 0);
        chk("rrun_pass_cnt", int'(pass_cnt), 0);
        chk("rrun_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        repeat (5) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
